// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start bit, DATA_BITS LSB-first, optional parity, STOP_BITS stop bits, paced by baud_en.
// Defining UART_TX_FIFO_EN adds a FIFO_DEPTH-entry write FIFO and back-to-back frames with no idle gap.
module uart_tx_param #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_en,
    input  logic                 wr_en,
    input  logic [DATA_BITS-1:0] data_in,
    output logic                 wr_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 done
);
    localparam int IDX_W  = $clog2(DATA_BITS + 1);
    localparam int STOP_W = (STOP_BITS > 1) ? $clog2(STOP_BITS) : 1;
    localparam logic [IDX_W-1:0]  IDX_END   = IDX_W'(DATA_BITS);
    localparam logic [STOP_W-1:0] STOP_LAST = STOP_W'(STOP_BITS - 1);
    localparam logic              PAR_ODD   = (PARITY == 2);

    if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
        STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
        $error("uart_tx_param: illegal parameter value");
    end

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t               r_state, w_state_nx;
    logic [DATA_BITS-1:0] r_shift, w_shift_nx;
    logic [IDX_W-1:0]     r_idx,   w_idx_nx;
    logic [STOP_W-1:0]    r_stop,  w_stop_nx;
    logic                 r_par,   w_par_nx;
    logic                 r_tx,    w_tx_nx;
    logic                 w_avail;
    logic                 w_load;
    logic [DATA_BITS-1:0] w_src;

`ifdef UART_TX_FIFO_EN
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam bit B2B   = 1'b1;

    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     r_wptr, r_rptr;
    logic [PTR_W:0]       r_cnt;
    logic                 w_full, w_empty, w_push;

    assign w_full   = (r_cnt == (PTR_W + 1)'(FIFO_DEPTH));
    assign w_empty  = (r_cnt == '0);
    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign wr_ready = !w_full || w_load;
    assign w_push   = wr_en && wr_ready;
    assign w_avail  = !w_empty;
    assign w_src    = r_mem[r_rptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_load) r_rptr <= r_rptr + 1'b1;
            if (w_push && !w_load)      r_cnt <= r_cnt + 1'b1;
            else if (!w_push && w_load) r_cnt <= r_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= data_in;
    end
`else
    localparam bit B2B = 1'b0;

    assign wr_ready = (r_state == S_IDLE);
    assign w_avail  = wr_en;
    assign w_src    = data_in;
`endif

    always_comb begin
        w_state_nx = r_state;
        w_shift_nx = r_shift;
        w_idx_nx   = r_idx;
        w_stop_nx  = r_stop;
        w_par_nx   = r_par;
        w_tx_nx    = r_tx;
        w_load     = 1'b0;
        done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_avail) begin
                    w_load     = 1'b1;
                    w_state_nx = S_START;
                end
            end
            S_START: begin
                if (baud_en) begin
                    w_tx_nx    = 1'b0;
                    w_idx_nx   = '0;
                    w_state_nx = S_DATA;
                end
            end
            S_DATA: begin
                if (baud_en) begin
                    // r_idx counts bits already on the line; at IDX_END this tick closes the last data bit.
                    if (r_idx == IDX_END) begin
                        if (PARITY != 0) begin
                            w_tx_nx    = r_par;
                            w_state_nx = S_PARITY;
                        end else begin
                            w_tx_nx    = 1'b1;
                            w_stop_nx  = '0;
                            w_state_nx = S_STOP;
                        end
                    end else begin
                        w_tx_nx    = r_shift[0];
                        w_shift_nx = r_shift >> 1;
                        w_idx_nx   = r_idx + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (baud_en) begin
                    w_tx_nx    = 1'b1;
                    w_stop_nx  = '0;
                    w_state_nx = S_STOP;
                end
            end
            S_STOP: begin
                if (baud_en) begin
                    if (r_stop == STOP_LAST) begin
                        done = 1'b1;
                        if (B2B && w_avail) begin
                            w_load     = 1'b1;
                            w_tx_nx    = 1'b0;
                            w_idx_nx   = '0;
                            w_state_nx = S_DATA;
                        end else begin
                            w_state_nx = S_IDLE;
                        end
                    end else begin
                        w_stop_nx = r_stop + 1'b1;
                    end
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
        if (w_load) begin
            w_shift_nx = w_src;
            w_par_nx   = (^w_src) ^ PAR_ODD;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_idx   <= '0;
            r_stop  <= '0;
            r_par   <= 1'b0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_nx;
            r_shift <= w_shift_nx;
            r_idx   <= w_idx_nx;
            r_stop  <= w_stop_nx;
            r_par   <= w_par_nx;
            r_tx    <= w_tx_nx;
        end
    end

    assign tx   = r_tx;
    assign busy = (r_state != S_IDLE);
endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: six parameter sets share clk/rst/baud_en; each frame is rebuilt from the
// UART framing rules and compared bit-per-interval against the captured line.
module tb_uart_tx_param;
    localparam int NI = 6;
    localparam int DB [NI] = '{8, 7, 8, 8, 9, 5};
    localparam int PB [NI] = '{0, 1, 2, 1, 2, 0};
    localparam int SB [NI] = '{1, 2, 1, 1, 2, 1};

    logic       clk = 1'b0;
    logic       rst;
    logic       baud_en;
    logic       wr_en    [NI];
    logic [8:0] din      [NI];
    logic       wr_ready [NI];
    logic       tx       [NI];
    logic       busy     [NI];
    logic       done     [NI];

    int checks = 0;
    int failures = 0;
    int baud_div = 16;
    int bcnt = 0;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int W = DB[g];
        uart_tx_param #(.DATA_BITS(DB[g]), .PARITY(PB[g]), .STOP_BITS(SB[g]), .FIFO_DEPTH(4)) u_dut (
            .clk      (clk),
            .rst      (rst),
            .baud_en  (baud_en),
            .wr_en    (wr_en[g]),
            .data_in  (din[g][W-1:0]),
            .wr_ready (wr_ready[g]),
            .tx       (tx[g]),
            .busy     (busy[g]),
            .done     (done[g])
        );
    end

    initial forever #5 clk = ~clk;

    initial begin
        baud_en = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (baud_div <= 1) baud_en = 1'b1;
            else begin
                bcnt = (bcnt + 1) % baud_div;
                baud_en = (bcnt == 0);
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Line image of one frame: bit i is the level during the i-th baud interval.
    function automatic void model(input int k, input logic [8:0] d, output logic [63:0] bits, output int n);
        int ones;
        ones = 0;
        bits = '1;
        n = 0;
        bits[n] = 1'b0; n++;
        for (int i = 0; i < DB[k]; i++) begin
            bits[n] = d[i];
            ones += int'(d[i]);
            n++;
        end
        if (PB[k] == 1) begin bits[n] = (ones % 2 == 1); n++; end
        else if (PB[k] == 2) begin bits[n] = (ones % 2 == 0); n++; end
        for (int i = 0; i < SB[k]; i++) begin bits[n] = 1'b1; n++; end
    endfunction

    task automatic do_write(input int k, input logic [8:0] d);
        @(posedge clk); #1;
        wr_en[k] = 1'b1;
        din[k]   = d;
        @(posedge clk); #1;
        wr_en[k] = 1'b0;
        din[k]   = 9'($urandom);
    endtask

    // Observes instance k for nexp intervals plus the closing tick; records, never judges.
    task automatic capture(input int k, input int nexp, output logic [63:0] bits, output int done_cnt,
                           output int done_tick, output int busy_low, output int glitches, output int rdy_hi,
                           output bit timeout, output logic tx_after, output logic busy_after,
                           output logic rdy_after);
        int ticks, cyc;
        logic prev_tick, prev_t, t;
        bits = '1; done_cnt = 0; done_tick = 0; busy_low = 0; glitches = 0; rdy_hi = 0;
        ticks = 0; cyc = 0; prev_tick = 1'b0; prev_t = 1'b1;
        while (ticks < nexp + 1 && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            t = tx[k];
            if (prev_tick) begin
                if (ticks >= 1 && ticks <= 64) bits[ticks-1] = t;
            end else if (t !== prev_t) glitches++;
            if (busy[k] !== 1'b1) busy_low++;
            if (wr_ready[k] === 1'b1) rdy_hi++;
            if (done[k] === 1'b1) begin
                done_cnt++;
                done_tick = ticks + 1;
            end
            if (baud_en) begin
                ticks++;
                if (ticks == nexp + 1) wr_en[k] = 1'b0;
            end
            prev_tick = baud_en;
            prev_t = t;
        end
        timeout = (ticks < nexp + 1);
        @(negedge clk);
        tx_after = tx[k]; busy_after = busy[k]; rdy_after = wr_ready[k];
        if (done[k] === 1'b1) done_cnt++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int k = 0; k < NI; k++) begin
            wr_en[k] = 1'b0;
            din[k] = '0;
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            checks++;
            if (tx[k] !== 1'b1 || busy[k] !== 1'b0 || done[k] !== 1'b0 || wr_ready[k] !== 1'b1) begin
                failures++;
                $display("FAIL reset_outs[%0d] tx=%b busy=%b done=%b rdy=%b want 1 0 0 1",
                         k, tx[k], busy[k], done[k], wr_ready[k]);
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_basic_a5();
        logic [63:0] bits; int dc, dt, bl, gl, rh; bit to; logic ta, ba, ra;
        baud_div = 16;
        do_write(0, 9'h0A5);
        capture(0, 10, bits, dc, dt, bl, gl, rh, to, ta, ba, ra);
        checks++;
        if (bits[9:0] !== 10'h34A) begin
            failures++; $display("FAIL a5_bits got=%b want=%b", bits[9:0], 10'h34A);
        end
        checks++;
        if (dc !== 1 || dt !== 11) begin
            failures++; $display("FAIL a5_done count=%0d tick=%0d want 1 11", dc, dt);
        end
        checks++;
        if (bl !== 0 || gl !== 0 || to !== 1'b0) begin
            failures++; $display("FAIL a5_protocol busy_low=%0d glitches=%0d timeout=%0b want 0 0 0", bl, gl, to);
        end
        checks++;
        if (ta !== 1'b1 || ba !== 1'b0 || ra !== 1'b1) begin
            failures++; $display("FAIL a5_after tx=%b busy=%b rdy=%b want 1 0 1", ta, ba, ra);
        end
    endtask

    task automatic test_param_frame();
        logic [63:0] bits; int dc, dt, bl, gl, rh; bit to; logic ta, ba, ra;
        baud_div = 16;
        do_write(1, 9'h035);
        capture(1, 11, bits, dc, dt, bl, gl, rh, to, ta, ba, ra);
        checks++;
        if (bits[10:0] !== 11'h66A) begin
            failures++; $display("FAIL p7e2_bits got=%b want=%b", bits[10:0], 11'h66A);
        end
        checks++;
        if (dc !== 1 || dt !== 12 || bl !== 0 || gl !== 0 || ba !== 1'b0) begin
            failures++;
            $display("FAIL p7e2_frame done=%0d tick=%0d busy_low=%0d glitches=%0d busy_after=%b want 1 12 0 0 0",
                     dc, dt, bl, gl, ba);
        end
    endtask

    task automatic test_parity();
        int          ks   [4] = '{2, 2, 3, 3};
        logic [8:0]  ds   [4] = '{9'h000, 9'h0FF, 9'h000, 9'h0FF};
        logic        want [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic [63:0] bits; int dc, dt, bl, gl, rh; bit to; logic ta, ba, ra;
        baud_div = 5;
        for (int i = 0; i < 4; i++) begin
            do_write(ks[i], ds[i]);
            capture(ks[i], 11, bits, dc, dt, bl, gl, rh, to, ta, ba, ra);
            checks++;
            if (bits[9] !== want[i] || dc !== 1 || dt !== 12) begin
                failures++;
                $display("FAIL parity_bit[%0d] inst=%0d data=%h got=%b want=%b done=%0d tick=%0d",
                         i, ks[i], ds[i], bits[9], want[i], dc, dt);
            end
        end
    endtask

`ifndef UART_TX_FIFO_EN
    task automatic test_ignore_busy();
        logic [63:0] bits, expb; int n, dc, dt, bl, gl, rh, bad; bit to; logic ta, ba, ra;
        baud_div = 16;
        @(posedge clk); #1;
        wr_en[0] = 1'b1; din[0] = 9'h012;
        @(posedge clk); #1;
        din[0] = 9'h034;
        capture(0, 10, bits, dc, dt, bl, gl, rh, to, ta, ba, ra);
        model(0, 9'h012, expb, n);
        checks++;
        if (bits !== expb || dc !== 1) begin
            failures++; $display("FAIL ignore_frame got=%h want=%h done=%0d", bits[9:0], expb[9:0], dc);
        end
        checks++;
        if (rh !== 0 || ra !== 1'b1) begin
            failures++; $display("FAIL ignore_ready high_while_busy=%0d rdy_after=%b want 0 1", rh, ra);
        end
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (tx[0] !== 1'b1 || busy[0] !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++; $display("FAIL ignore_no_second_frame active_cycles=%0d want 0", bad);
        end
    endtask
`endif

    task automatic test_reset_mid();
        logic [63:0] bits; int dc, dt, bl, gl, rh, ticks, cyc, dn; bit to; logic ta, ba, ra;
        baud_div = 16;
        do_write(0, 9'h000);
        ticks = 0; cyc = 0;
        while (ticks < 5 && cyc < 400) begin
            @(negedge clk); cyc++;
            if (baud_en) ticks++;
        end
        @(negedge clk);
        checks++;
        if (tx[0] !== 1'b0 || busy[0] !== 1'b1) begin
            failures++; $display("FAIL rstmid_pre tx=%b busy=%b want 0 1", tx[0], busy[0]);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (tx[0] !== 1'b1 || busy[0] !== 1'b0 || done[0] !== 1'b0 || wr_ready[0] !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_async tx=%b busy=%b done=%b rdy=%b want 1 0 0 1", tx[0], busy[0], done[0], wr_ready[0]);
        end
        dn = 0;
        repeat (3) begin
            @(negedge clk);
            if (done[0] !== 1'b0 || tx[0] !== 1'b1) dn++;
        end
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (dn !== 0) begin
            failures++; $display("FAIL rstmid_hold bad_cycles=%0d want 0", dn);
        end
        do_write(0, 9'h05A);
        capture(0, 10, bits, dc, dt, bl, gl, rh, to, ta, ba, ra);
        checks++;
        if (bits[9:0] !== 10'h2B4 || dc !== 1 || dt !== 11 || gl !== 0) begin
            failures++;
            $display("FAIL rstmid_next got=%b want=%b done=%0d tick=%0d glitches=%0d", bits[9:0], 10'h2B4, dc, dt, gl);
        end
    endtask

    task automatic test_continuous();
        logic [63:0] bits, expb; int n, dc, dt, bl, gl, rh; bit to; logic ta, ba, ra;
        logic [8:0] d;
        baud_div = 1;
        for (int k = 4; k < NI; k++) begin
            d = 9'($urandom) & 9'((1 << DB[k]) - 1);
            model(k, d, expb, n);
            do_write(k, d);
            capture(k, n, bits, dc, dt, bl, gl, rh, to, ta, ba, ra);
            checks++;
            if (bits !== expb || dc !== 1 || dt !== n + 1 || bl !== 0 || ba !== 1'b0) begin
                failures++;
                $display("FAIL continuous[%0d] data=%h got=%h want=%h done=%0d tick=%0d busy_low=%0d",
                         k, d, bits[15:0], expb[15:0], dc, dt, bl);
            end
        end
    endtask

    task automatic test_random();
        int divs [5] = '{1, 2, 3, 7, 16};
        logic [63:0] bits, expb; int n, k, dc, dt, bl, gl, rh; bit to; logic ta, ba, ra;
        logic [8:0] d;
        for (int it = 0; it < 14; it++) begin
            k = int'($urandom_range(NI - 1, 0));
            d = 9'($urandom) & 9'((1 << DB[k]) - 1);
            baud_div = divs[$urandom_range(4, 0)];
            repeat ($urandom_range(20, 0)) @(posedge clk);
            model(k, d, expb, n);
            do_write(k, d);
            capture(k, n, bits, dc, dt, bl, gl, rh, to, ta, ba, ra);
            checks++;
            if (bits !== expb) begin
                failures++;
                $display("FAIL rand_bits[%0d] inst=%0d data=%h got=%h want=%h", it, k, d, bits[15:0], expb[15:0]);
            end
            checks++;
            if (dc !== 1 || dt !== n + 1 || bl !== 0 || gl !== 0 || to !== 1'b0 ||
                ta !== 1'b1 || ba !== 1'b0 || ra !== 1'b1) begin
                failures++;
                $display("FAIL rand_proto[%0d] done=%0d tick=%0d/%0d busy_low=%0d glitches=%0d to=%0b after=%b%b%b",
                         it, dc, dt, n + 1, bl, gl, to, ta, ba, ra);
            end
        end
    endtask

`ifdef UART_TX_FIFO_EN
    task automatic test_fifo_b2b();
        logic [63:0] bits, expb, fb; int n, tot, c, dc, dt, bl, gl, rh; bit to; logic ta, ba, ra;
        baud_div = 16;
        c = 0;
        do begin @(negedge clk); c++; end while (!baud_en && c < 100);
        for (int i = 1; i <= 5; i++) begin
            @(posedge clk); #1;
            wr_en[0] = 1'b1; din[0] = 9'(i);
        end
        @(posedge clk); #1;
        wr_en[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (wr_ready[0] !== 1'b0) begin
            failures++; $display("FAIL fifo_full_ready got=%b want 0", wr_ready[0]);
        end
        expb = '1; tot = 0;
        for (int f = 1; f <= 5; f++) begin
            model(0, 9'(f), fb, n);
            for (int i = 0; i < n; i++) expb[tot + i] = fb[i];
            tot += n;
        end
        capture(0, tot, bits, dc, dt, bl, gl, rh, to, ta, ba, ra);
        checks++;
        if (bits !== expb) begin
            failures++; $display("FAIL fifo_b2b_bits got=%h want=%h", bits, expb);
        end
        checks++;
        if (dc !== 5 || dt !== tot + 1 || bl !== 0 || gl !== 0 || ba !== 1'b0 || ra !== 1'b1) begin
            failures++;
            $display("FAIL fifo_b2b_proto done=%0d tick=%0d busy_low=%0d glitches=%0d busy_after=%b rdy_after=%b want 5 %0d 0 0 0 1",
                     dc, dt, bl, gl, ba, ra, tot + 1);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_a5();
        test_param_frame();
        test_parity();
`ifndef UART_TX_FIFO_EN
        test_ignore_busy();
`endif
        test_reset_mid();
        test_continuous();
        test_random();
`ifdef UART_TX_FIFO_EN
        test_fifo_b2b();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
Parametrised UART transmitter, the next generation of the 8N1 serialiser. It supports configurable data width, parity mode and stop-bit count, and uses a valid/ready write handshake and a frame-done pulse. It sits between the host write interface and the tx pin. Bit timing comes from a shared one-cycle baud_en tick supplied by the baud generator.

Parameters:
- DATA_BITS, 8: data bits per frame; legal 5..9.
- PARITY, 0: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: stop bits per frame; legal 1 or 2.
- FIFO_DEPTH, 4: TX FIFO entries, power of 2, ≥2. Used only when UART_TX_FIFO_EN is defined; ignored otherwise.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- baud_en  in  1  one-clk-wide bit-rate tick
- wr_en  in  1  write request; data_in captured when wr_en && wr_ready
- data_in  in  DATA_BITS  parallel word, transmitted LSB first
- wr_ready  out  1  core can accept a word this cycle
- tx  out  1  serial line, idle high
- busy  out  1  frame in progress (engine not IDLE)
- done  out  1  one-clk pulse at the end of each frame's last stop bit

Behaviour:
- Reset (async, any time including mid-frame):
  - tx=1, busy=0, done=0, wr_ready=1.
  - FSM returns to IDLE; bit and stop counters clear; FIFO (if present) empties.
  - Partial frame is abandoned, with no glitch low on tx.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: on accepted write, latch data_in into the shift register and go to START. tx stays 1.
  - START: on baud_en, tx<=0, idx<=0, go to DATA.
  - DATA: on each baud_en, tx<=data[idx] and idx++. The tick following the bit with idx=DATA_BITS-1 goes to PARITY if PARITY≠0, else to STOP; that tick drives the parity or stop value, not another data bit.
  - PARITY: parity bit is held for one baud interval, then STOP. Even parity = XOR of data bits; odd parity = its inverse.
  - STOP: tx=1 for STOP_BITS baud intervals. On the baud_en ending the last stop bit: done=1 for that cycle and the FSM returns to IDLE (or starts the next frame, see the optional feature).
- Every bit occupies exactly one baud_en-to-baud_en interval.
  - Frame length = 1 + DATA_BITS + (PARITY≠0) + STOP_BITS intervals, counted from the first baud_en after acceptance.
  - Latency from acceptance to the start-bit edge: the first baud_en strictly after the acceptance cycle.
  - tx changes only in cycles where baud_en=1.
- Handshake:
  - Without the FIFO: wr_ready = !busy. wr_en while wr_ready=0 is ignored; data is dropped and no state changes.
  - Data latched at acceptance is immune to later data_in changes.
- baud_en asserted in the same cycle as acceptance does not start the frame; the start bit waits for the next tick.
- baud_en held high continuously is legal: one bit per clk.
- Counters are sized $clog2 of their maximum count. No arithmetic wraps inside a frame.

Optional Feature:
- Macro: UART_TX_FIFO_EN.
- Defined:
  - A FIFO_DEPTH-entry write FIFO sits in front of the engine; wr_ready = !fifo_full.
  - Writes while full are dropped, and FIFO contents stay unchanged.
  - Engine pops when IDLE and the FIFO is non-empty, entering START the next cycle.
  - Back-to-back frames: on the baud_en ending the last stop bit, if the FIFO is non-empty, the engine pops, drives tx<=0 on that same tick and goes to DATA, giving no idle gap. done still pulses.
  - Simultaneous push and pop when full succeeds; count is unchanged.
  - busy stays asserted across back-to-back frames.
- Undefined: no FIFO logic is generated; wr_ready = !busy; frames are separated by at least one idle interval.

Test Plan:
- Defaults, write 0xA5, baud_en every 16 clk → tx = 0,1,0,1,0,0,1,0,1,1 per interval; done pulses once; busy high for 10 intervals; wr_ready=1 after done.
- DATA_BITS=7, PARITY=1, STOP_BITS=2, write 0x35 → tx = 0,1,0,1,0,1,1,0,0,1,1; frame is 11 intervals.
- PARITY=2, write 0x00 → parity bit 1. Write 0xFF with DATA_BITS=8 → parity bit 1 (odd). Repeat with PARITY=1 → 0 in both cases.
- Write 0x12 accepted, then wr_en with 0x34 while busy (no FIFO) → second word ignored; exactly one frame transmitted carrying 0x12.
- Assert rst at the 4th data bit → tx=1 within the same cycle; busy=0; no done pulse. Next write of 0x5A transmits a complete, correct frame.
- UART_TX_FIFO_EN, FIFO_DEPTH=4, push 0x01,0x02,0x03,0x04,0x05 on consecutive clks → wr_ready low after the 4th or 5th push (per pop timing); 0x05 dropped if full. Frames are back-to-back with no extra high interval between stop and start; done pulses once per frame.
